// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM with memory-wait timeout.
// Optional illegal-opcode trap state enabled by defining MC_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] ImmSrc,
  output logic       mem_err,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, JAL, ALUWB,
`ifdef MC_ILLEGAL_TRAP_EN
    ILLEGAL,
`endif
    BEQ
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       waiting, timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    AluSrcA   = 2'b00;
    AluSrcB   = 2'b00;
    AluOp     = 2'b00;

    // Counter restarts whenever a wait state is (re)entered or left.
    waiting = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    timeout = waiting && !mem_ready && (cnt_q == TMO_LAST);
    cnt_d   = (waiting && !mem_ready && !timeout) ? cnt_q + 8'd1 : '0;
    mem_err = timeout;

    case (state_q)
      FETCH: begin
        AluSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // Handshake enables are gated by rst_n so they stay low while reset is held.
        IRWrite   = mem_ready & rst_n;
        PCWrite   = mem_ready & rst_n;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b01;
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = ILLEGAL;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        state_d = (Op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        AluSrcA = 2'b10;
        AluOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECI: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        AluOp   = 2'b10;
        state_d = ALUWB;
      end
      JAL: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        AluSrcA = 2'b10;
        AluOp   = 2'b01;
        PCWrite = Zero;
        state_d = FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ILLEGAL: state_d = ILLEGAL;
`endif
      default: state_d = FETCH;
    endcase

    if (timeout) state_d = FETCH;
  end

  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb illegal_d = illegal_q | (state_d == ILLEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
